// File: rtl/i2s_tx.sv
// I2S transmitter: derives mclk/sck/lrck from one free-running counter
// and serialises a double-buffered stereo sample pair, MSB first.
module i2s_tx #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              sample_tick,
  output logic              underrun,
  output logic              mclk,
  output logic              sck,
  output logic              lrck,
  output logic              sdout
);

  localparam logic [5:0] LP_DW = 6'(DATA_W);

  logic [10:0]       r_cnt;
  logic              r_full;
  logic [DATA_W-1:0] r_buf_l;
  logic [DATA_W-1:0] r_buf_r;
  logic [DATA_W-1:0] r_frm_l;
  logic [DATA_W-1:0] r_frm_r;
  logic              r_sdout;
  logic              r_tick;
  logic              r_under;

  logic [10:0]       w_cnt_nx;
  logic              w_fs;
  logic              w_acc;
  logic              w_load;
  logic [4:0]        w_slot;
  logic [DATA_W-1:0] w_word;
  logic [5:0]        w_idx;
  logic [DATA_W-1:0] w_mask;
  logic              w_in;
  logic              w_bit;

  assign w_cnt_nx = r_cnt + 11'd1;
  assign w_fs     = (r_cnt == 11'h7FF);
  assign w_acc    = s_valid & ~r_full;
  assign w_load   = w_fs & r_full;

  // Slot and channel of the bit that becomes current on the next edge.
  assign w_slot = w_cnt_nx[9:5];
  assign w_word = w_cnt_nx[10] ? r_frm_r : r_frm_l;
  assign w_idx  = LP_DW - {1'b0, w_slot};
  assign w_mask = DATA_W'(1) << w_idx;
  assign w_in   = (w_slot != 5'd0) && ({1'b0, w_slot} <= LP_DW);
  assign w_bit  = w_in & (|(w_word & w_mask));

  // Free-running frame counter; all serial clocks are taps of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_cnt_nx;
  end

  // Holding buffer: frame start drains it, otherwise accept when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_buf_l <= '0;
      r_buf_r <= '0;
    end else if (w_load) begin
      r_full  <= 1'b0;
    end else if (w_acc) begin
      r_full  <= 1'b1;
      r_buf_l <= s_left;
      r_buf_r <= s_right;
    end
  end

  // Frame registers load both channels together at frame start only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frm_l <= '0;
      r_frm_r <= '0;
    end else if (w_load) begin
      r_frm_l <= r_buf_l;
      r_frm_r <= r_buf_r;
    end
  end

  // Frame-start and starvation pulses, one clk wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_tick  <= w_fs;
      r_under <= w_fs & ~r_full;
    end
  end

  // Serial data changes only when a new slot begins (sck falling).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_sdout <= 1'b0;
    else if (w_cnt_nx[4:0] == 5'd0) r_sdout <= w_bit;
  end

  assign s_ready     = ~r_full;
  assign sample_tick = r_tick;
  assign underrun    = r_under;
  assign mclk        = r_cnt[1];
  assign sck         = r_cnt[4];
  assign lrck        = r_cnt[10];
  assign sdout       = r_sdout;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed self-checking bench for i2s_tx (DATA_W = 16).
// Tracks the frame counter and expected frame words, checks every clk.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_left = '0;
  logic [15:0] s_right = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, sample_tick, underrun;
  logic        mclk, sck, lrck, sdout;

  i2s_tx #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_left(s_left), .s_right(s_right),
    .s_valid(s_valid), .s_ready(s_ready),
    .sample_tick(sample_tick), .underrun(underrun),
    .mclk(mclk), .sck(sck), .lrck(lrck), .sdout(sdout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int bad = 0;
  int und_n = 0;
  int tick_n = 0;
  logic [10:0] t_cnt = '0;
  logic [15:0] cur_l = '0, cur_r = '0;
  logic [15:0] nxt_l = '0, nxt_r = '0;

  logic [15:0] pl [4] = '{16'h1234, 16'h8001, 16'hFFFF, 16'h5A5A};
  logic [15:0] pr [4] = '{16'hFEDC, 16'h0002, 16'h0000, 16'hC3C3};

  // One clk; model counter advances, then all free-running outputs checked.
  task automatic step();
    logic [4:0]  k;
    logic [15:0] w;
    logic        e;
    @(posedge clk); #1;
    t_cnt = t_cnt + 11'd1;
    if (t_cnt == 11'd0) begin
      cur_l = nxt_l;
      cur_r = nxt_r;
    end
    k = t_cnt[9:5];
    w = t_cnt[10] ? cur_r : cur_l;
    e = (k >= 5'd1 && k <= 5'd16) ? w[16 - int'(k)] : 1'b0;
    if (mclk !== t_cnt[1] || sck !== t_cnt[4] || lrck !== t_cnt[10] ||
        sdout !== e || sample_tick !== (t_cnt == 11'd0))
      bad++;
    if (sample_tick === 1'b1) tick_n++;
    if (underrun === 1'b1) und_n++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    t_cnt = '0;
    cur_l = '0; cur_r = '0; nxt_l = '0; nxt_r = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({mclk, sck, lrck, sdout, sample_tick, underrun, s_ready} !== 7'b0000001)
      $display("FAIL reset_outs got=%b want=0000001",
               {mclk, sck, lrck, sdout, sample_tick, underrun, s_ready});
    else n_pass++;
    do_reset();
  endtask

  task automatic test_idle();
    bad = 0; und_n = 0; tick_n = 0;
    repeat (3 * 2048) step();
    n_chk++;
    if (bad !== 0) $display("FAIL idle_wave bad_clks=%0d want=0", bad);
    else n_pass++;
    n_chk++;
    if (und_n !== 3) $display("FAIL idle_underrun got=%0d want=3", und_n);
    else n_pass++;
    n_chk++;
    if (tick_n !== 3) $display("FAIL idle_tick got=%0d want=3", tick_n);
    else n_pass++;
  endtask

  task automatic test_data();
    bad = 0; und_n = 0;
    repeat (499) step();
    s_left = 16'hA5C3; s_right = 16'h0F01; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    nxt_l = 16'hA5C3; nxt_r = 16'h0F01;
    n_chk++;
    if (s_ready !== 1'b0) $display("FAIL data_ready_full got=%b want=0", s_ready);
    else n_pass++;
    do step(); while (t_cnt != 11'd0);
    n_chk++;
    if (s_ready !== 1'b1) $display("FAIL data_ready_drain got=%b want=1", s_ready);
    else n_pass++;
    do step(); while (t_cnt != 11'd0);
    n_chk++;
    if (bad !== 0) $display("FAIL data_serial bad_clks=%0d want=0", bad);
    else n_pass++;
    n_chk++;
    if (und_n !== 1) $display("FAIL data_underrun got=%0d want=1", und_n);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int acc = 0;
    int rdy_bad = 0;
    logic rb;
    bad = 0; und_n = 0;
    s_left = pl[0]; s_right = pr[0]; s_valid = 1'b1;
    repeat (4 * 2048) begin
      rb = s_ready;
      step();
      if (rb && s_valid) begin
        acc++;
        nxt_l = pl[idx]; nxt_r = pr[idx];
        idx++;
        if (idx == 4) s_valid = 1'b0;
        else begin s_left = pl[idx]; s_right = pr[idx]; end
      end
      if (s_ready !== (t_cnt == 11'd0)) rdy_bad++;
    end
    s_valid = 1'b0;
    n_chk++;
    if (acc !== 4) $display("FAIL b2b_accepts got=%0d want=4", acc);
    else n_pass++;
    n_chk++;
    if (rdy_bad !== 0) $display("FAIL b2b_ready bad_clks=%0d want=0", rdy_bad);
    else n_pass++;
    n_chk++;
    if (und_n !== 0) $display("FAIL b2b_underrun got=%0d want=0", und_n);
    else n_pass++;
    n_chk++;
    if (bad !== 0) $display("FAIL b2b_serial bad_clks=%0d want=0", bad);
    else n_pass++;
  endtask

  task automatic test_repeat();
    bad = 0;
    while (t_cnt != 11'h7FF) step();
    s_left = 16'h2468; s_right = 16'h1357; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    n_chk++;
    if (underrun !== 1'b1) $display("FAIL rep_underrun got=%b want=1", underrun);
    else n_pass++;
    n_chk++;
    if (s_ready !== 1'b0) $display("FAIL rep_buffered got=%b want=0", s_ready);
    else n_pass++;
    nxt_l = 16'h2468; nxt_r = 16'h1357;
    und_n = 0;
    do step(); while (t_cnt != 11'd0);
    while (t_cnt != 11'h7FF) step();
    n_chk++;
    if (und_n !== 0) $display("FAIL rep_next_underrun got=%0d want=0", und_n);
    else n_pass++;
    n_chk++;
    if (bad !== 0) $display("FAIL rep_serial bad_clks=%0d want=0", bad);
    else n_pass++;
  endtask

  task automatic test_sign();
    logic [15:0] dl = '0, dr = '0;
    logic [4:0]  k;
    logic        ps;
    step();
    s_left = 16'h8000; s_right = 16'h7FFF; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    nxt_l = 16'h8000; nxt_r = 16'h7FFF;
    do step(); while (t_cnt != 11'd0);
    ps = sck;
    while (t_cnt != 11'h7FF) begin
      step();
      if (!ps && sck) begin
        k = t_cnt[9:5];
        if (k >= 5'd1 && k <= 5'd16) begin
          if (t_cnt[10]) dr = {dr[14:0], sdout};
          else           dl = {dl[14:0], sdout};
        end
      end
      ps = sck;
    end
    n_chk++;
    if (dl !== 16'h8000) $display("FAIL sign_left got=%h want=8000", dl);
    else n_pass++;
    n_chk++;
    if (dr !== 16'h7FFF) $display("FAIL sign_right got=%h want=7fff", dr);
    else n_pass++;
    n_chk++;
    if (dl[15] !== 1'b1) $display("FAIL sign_left_msb got=%b want=1", dl[15]);
    else n_pass++;
    n_chk++;
    if (dr[15] !== 1'b0) $display("FAIL sign_right_msb got=%b want=0", dr[15]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    step();
    s_left = 16'h1111; s_right = 16'h2222; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    while (t_cnt != 11'd700) step();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({mclk, sck, lrck, sdout, sample_tick, underrun, s_ready} !== 7'b0000001)
      $display("FAIL mid_reset_outs got=%b want=0000001",
               {mclk, sck, lrck, sdout, sample_tick, underrun, s_ready});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t_cnt = '0;
    cur_l = '0; cur_r = '0; nxt_l = '0; nxt_r = '0;
    bad = 0;
    do begin step(); n++; end while (lrck !== 1'b1 && n < 3000);
    n_chk++;
    if (n !== 1024) $display("FAIL mid_lrck_rise got=%0d want=1024", n);
    else n_pass++;
    repeat (4096) step();
    n_chk++;
    if (bad !== 0) $display("FAIL mid_sdout_zero bad_clks=%0d want=0", bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_data();
    test_back_to_back();
    test_repeat();
    test_sign();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
